// File: rtl/inst_prefetch.sv
// Purpose: sequential instruction prefetch buffer; req/gnt/rvalid memory side, valid/ready core side, flush on redirect.
// Latency: rvalid in cycle N presents the word on inst_valid_o in cycle N+1 (registered FIFO, no bypass).
// Backpressure: inst_ready_i low holds the head; requests stop once queued + in-flight words would fill DEPTH.
module inst_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUTST  = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        inst_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_addr;
    logic [31:0]   resp_addr;
    logic [31:0]   empty_addr;
    logic [31:0]   flush_tgt;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_left;
    logic [CW-1:0] discard;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic          run;
    logic          grant;
    logic          push;
    logic          pop;

    // Low two bits of the redirect target are dropped so fetches stay word aligned.
    assign flush_tgt  = flush_addr_i & ~32'h3;
    // Outstanding count after this cycle's response retires (guarded so it never wraps).
    assign outst_left = (mem_rvalid_i && outst != '0) ? outst - CW'(1) : outst;

    // A request needs a free in-flight slot and a reserved FIFO entry; flush withdraws it.
    assign mem_req_o  = run && !flush_i && (outst < CW'(MAX_OUTST))
                        && (({1'b0, count} + {1'b0, outst}) < (CW + 1)'(DEPTH));
    assign mem_addr_o = fetch_addr;
    assign grant      = mem_req_o && mem_gnt_i;
    assign push       = mem_rvalid_i && !flush_i && (discard == '0);
    assign pop        = inst_valid_o && inst_ready_i && !flush_i;

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? fifo_data[rd_ptr] : NOP;
    assign inst_addr_o  = inst_valid_o ? fifo_addr[rd_ptr] : empty_addr;

    // Keeps mem_req_o low while reset is asserted; requests begin the cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Fetch address: jumps to the redirect target, otherwise advances one word per grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       fetch_addr <= RESET_ADDR;
        else if (flush_i) fetch_addr <= flush_tgt;
        else if (grant)   fetch_addr <= fetch_addr + 32'd4;
    end

    // In-flight tracking; on a redirect every still-unanswered request becomes a word to drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst   <= '0;
            discard <= '0;
        end else begin
            outst <= grant ? outst_left + CW'(1) : outst_left;
            if (flush_i)
                discard <= outst_left;
            else if (mem_rvalid_i && discard != '0)
                discard <= discard - CW'(1);
        end
    end

    // Address tag for accepted responses, following fetch order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       resp_addr <= RESET_ADDR;
        else if (flush_i) resp_addr <= flush_tgt;
        else if (push)    resp_addr <= resp_addr + 32'd4;
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= resp_addr;
            fifo_data[wr_ptr] <= mem_rdata_i;
        end
    end

    // Address shown while empty: the word after the last one handed to the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   empty_addr <= 32'h0;
        else if (pop) empty_addr <= inst_addr_o + 32'd4;
    end
endmodule
